// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the sample FIFO: hides the one-cycle read latency behind a
// 2-entry skid buffer and presents samples on a valid/ready stream with frame marking.
module fifo_rd_ctrl #(
    parameter int unsigned DW        = 9,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          empty_r,
    output logic          enr_r,
    input  logic [DW-1:0] dataout_r,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          frame_done,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LastCnt = CW'(FRAME_LEN - 1);

    logic [1:0]    occ_q;
    logic          inflight_q;
    logic [DW-1:0] mem_q [2];
    logic          head_q;
    logic          tail_q;
    logic [CW-1:0] count_q;
    logic          frame_done_q;

    logic          pop;
    logic          last_cnt;
    logic [2:0]    occ_next;

    always_comb begin
        m_valid    = (occ_q != 2'd0);
        m_data     = mem_q[head_q];
        pop        = m_valid & m_ready;
        last_cnt   = (count_q == LastCnt);
        m_last     = m_valid & last_cnt;
        count      = count_q;
        frame_done = frame_done_q;
        // Entries the buffer will hold once this cycle's write and pop settle.
        occ_next   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        // A new read is only safe if its data will find a free slot next cycle.
        enr_r      = !empty_r && !rst && (occ_next < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (inflight_q) begin
                mem_q[tail_q] <= dataout_r;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q  <= ~head_q;
                count_q <= last_cnt ? '0 : count_q + CW'(1);
            end
            occ_q        <= occ_next[1:0];
            inflight_q   <= enr_r;
            frame_done_q <= pop & last_cnt;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO, cycle model of occupancy/counter and a
// scoreboard of samples written into the FIFO.
module tb_fifo_rd_ctrl;

    localparam int DW = 9;
    localparam int FL = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          empty_r = 1'b1;
    logic          enr_r;
    logic [DW-1:0] dataout_r = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          frame_done;
    logic [CW-1:0] count;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          mon_on = 1'b0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_q[$];

    int total = 0;
    int bad = 0;
    int n_enr = 0;
    int n_pop = 0;
    int m_occ = 0;
    int m_infl = 0;
    int m_cnt = 0;
    int m_fd = 0;

    fifo_rd_ctrl #(
        .DW(DW),
        .FRAME_LEN(FL),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .empty_r(empty_r),
        .enr_r(enr_r),
        .dataout_r(dataout_r),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .frame_done(frame_done),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Behavioural FIFO: read data appears the cycle after an accepted read.
    always @(posedge clk) begin
        logic [DW-1:0] d;
        if (enr_r && !empty_r) begin
            d = fifo_q.pop_front();
            dataout_r <= d;
        end
        if (wr_en) fifo_q.push_back(wr_data);
        empty_r <= (fifo_q.size() == 0);
    end

    // Cycle model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        bit pop_e;
        bit exp_enr;
        logic [DW-1:0] d;
        if (mon_on) begin
            pop_e   = (m_occ != 0) && m_ready;
            exp_enr = !empty_r && !rst && ((m_occ + m_infl - int'(pop_e)) < 2);
            check("enr_r", {31'b0, enr_r}, {31'b0, exp_enr});
            check("m_valid", {31'b0, m_valid}, (m_occ != 0) ? 1 : 0);
            check("count", {29'b0, count}, m_cnt);
            check("m_last", {31'b0, m_last}, ((m_occ != 0) && (m_cnt == FL - 1)) ? 1 : 0);
            check("frame_done", {31'b0, frame_done}, m_fd);
            if (enr_r) n_enr++;
            if (m_occ != 0) begin
                check("sb_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
                if (exp_q.size() != 0) check("m_data", {23'b0, m_data}, {23'b0, exp_q[0]});
            end
            if (rst) begin
                m_occ  = 0;
                m_infl = 0;
                m_cnt  = 0;
                m_fd   = 0;
                exp_q  = fifo_q;
                if (wr_en) exp_q.push_back(wr_data);
            end else begin
                if (pop_e) begin
                    n_pop++;
                    if (m_last) last_q.push_back(m_data);
                    if (exp_q.size() != 0) d = exp_q.pop_front();
                end
                m_fd   = (pop_e && (m_cnt == FL - 1)) ? 1 : 0;
                if (pop_e) m_cnt = (m_cnt == FL - 1) ? 0 : m_cnt + 1;
                m_occ  = m_occ + m_infl - int'(pop_e);
                m_infl = int'(exp_enr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int e0;
        int p0;
        int l0;
        int pat[8] = '{1, 0, 0, 0, 1, 1, 0, 1};

        // Reset with 5 samples waiting in the FIFO
        tick();
        mon_on = 1'b1;
        for (int i = 0; i < 5; i++) write(DW'(9'h0A0 + i));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_enr", {31'b0, enr_r}, 0);
            check("rst_valid", {31'b0, m_valid}, 0);
            check("rst_data", {23'b0, m_data}, 0);
            check("rst_count", {29'b0, count}, 0);
            check("rst_fd", {31'b0, frame_done}, 0);
        end
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        check("rel_valid_t1", {31'b0, m_valid}, 0);
        tick();
        check("rel_valid_t2", {31'b0, m_valid}, 1);
        check("rel_data_t2", {23'b0, m_data}, 9'h0A0);
        repeat (8) tick();

        // Streaming: 20 samples preloaded, one per cycle
        rst = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) write(DW'(i));
        m_ready = 1'b1;
        rst = 1'b0;
        e0 = n_enr;
        tick();
        tick();
        p0 = n_pop;
        repeat (20) tick();
        check("stream_pops", n_pop - p0, 20);
        check("stream_enr", n_enr - e0, 20);
        check("stream_drained", exp_q.size(), 0);

        // Backpressure pattern
        rst = 1'b1;
        for (int i = 0; i < 20; i++) write(DW'(i));
        rst = 1'b0;
        p0 = n_pop;
        for (int i = 0; i < 64; i++) begin
            m_ready = pat[i % 8][0];
            tick();
        end
        m_ready = 1'b1;
        repeat (4) tick();
        check("bp_pops", n_pop - p0, 20);
        check("bp_drained", exp_q.size(), 0);

        // Sparse writes with empty gaps
        p0 = n_pop;
        for (int i = 0; i < 6; i++) begin
            write(DW'(9'h150 + i));
            tick();
            tick();
        end
        repeat (4) tick();
        check("gap_pops", n_pop - p0, 6);

        // Frame boundaries with FRAME_LEN=4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        l0 = last_q.size();
        for (int i = 0; i < 9; i++) write(DW'(9'h1F0 + i));
        repeat (6) tick();
        check("frame_nlast", last_q.size() - l0, 2);
        if (last_q.size() - l0 == 2) begin
            check("frame_last0", {23'b0, last_q[l0]}, 9'h1F3);
            check("frame_last1", {23'b0, last_q[l0 + 1]}, 9'h1F7);
        end
        check("frame_count_end", {29'b0, count}, 1);

        // Reset while the skid buffer is full and stalled
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) write(DW'(9'h0C0 + i));
        for (int i = 0; i < 20 && m_occ != 2; i++) tick();
        check("mid_occ_full", m_occ, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", {31'b0, m_valid}, 0);
        check("mid_count", {29'b0, count}, 0);
        m_ready = 1'b1;
        tick();
        tick();
        check("mid_head", {23'b0, m_data}, 9'h0C2);
        repeat (10) tick();
        check("mid_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
